// File: rtl/cam_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cam_ctrl_if
//  Description : Request/response handshake bundle between a requester and
//                the CAM controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cam_ctrl_if #(
    parameter int WORD_SIZE   = 16,
    parameter int ENTRY_WIDTH = 7
);
    logic                   req_valid;
    logic                   req_ready;
    logic [1:0]             req_op;
    logic [WORD_SIZE-1:0]   req_data;
    logic [ENTRY_WIDTH-1:0] req_addr;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic                   rsp_hit;
    logic [ENTRY_WIDTH-1:0] rsp_addr;
    logic                   rsp_evict;

    modport master (
        output req_valid, req_op, req_data, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_hit, rsp_addr, rsp_evict
    );

    modport slave (
        input  req_valid, req_op, req_data, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_hit, rsp_addr, rsp_evict
    );
endinterface
`default_nettype wire

// File: rtl/cam_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cam_ctrl
//  Description : Search/insert/delete controller for a latch-based CAM array.
//  Revision    : 1.0 - initial release
// ============================================================================
module cam_ctrl #(
    parameter int WORD_SIZE   = 16,
    parameter int ROW_NUM     = 68,
    parameter int ENTRY_WIDTH = 7
) (
    input  wire                     clk,
    input  wire                     rst,
    cam_ctrl_if.slave               bus,
    output logic [ENTRY_WIDTH:0]    entry_count,
    output logic [WORD_SIZE-1:0]    cam_data,
    output logic [ROW_NUM-1:0]      cam_write_en,
    output logic                    cam_search_en,
    input  wire  [ROW_NUM-1:0]      cam_match_array
);

    localparam logic [1:0] c_op_search = 2'b00;
    localparam logic [1:0] c_op_insert = 2'b01;
    localparam logic [1:0] c_op_delete = 2'b10;
    localparam logic [ENTRY_WIDTH:0]   c_row_num  = (ENTRY_WIDTH+1)'(ROW_NUM);
    localparam logic [ENTRY_WIDTH-1:0] c_last_row = ENTRY_WIDTH'(ROW_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEARCH = 3'd1,
        S_EVAL   = 3'd2,
        S_WRITE  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             op_q, op_d;
    logic [ROW_NUM-1:0]     valid_q, valid_d;
    logic [ROW_NUM-1:0]     hitvec_q, hitvec_d;
    logic [ENTRY_WIDTH-1:0] victim_q, victim_d;
    logic [ENTRY_WIDTH-1:0] target_q, target_d;
    logic                   evict_q, evict_d;
    logic [ENTRY_WIDTH:0]   count_q, count_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_hit_q, rsp_hit_d;
    logic [ENTRY_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
    logic                   rsp_evict_q, rsp_evict_d;
    logic [ROW_NUM-1:0]     cam_write_en_q, cam_write_en_d;
    logic                   cam_search_en_q, cam_search_en_d;
    logic [WORD_SIZE-1:0]   cam_data_q, cam_data_d;

    logic                   w_hit_found;
    logic [ENTRY_WIDTH-1:0] w_hit_idx;
    logic                   w_free_found;
    logic [ENTRY_WIDTH-1:0] w_free_idx;
    logic [ENTRY_WIDTH-1:0] w_ins_target;
    logic                   w_del_in_range;

    // Lowest-index priority encoders over the snapshot hits and the free rows
    always_comb begin
        w_hit_found  = 1'b0;
        w_hit_idx    = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = ROW_NUM - 1; i >= 0; i--) begin
            if (hitvec_q[i]) begin
                w_hit_found = 1'b1;
                w_hit_idx   = ENTRY_WIDTH'(i);
            end
            if (!valid_q[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = ENTRY_WIDTH'(i);
            end
        end
    end

    assign w_ins_target   = w_free_found ? w_free_idx : victim_q;
    assign w_del_in_range = ({1'b0, bus.req_addr} < c_row_num);

    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        valid_d         = valid_q;
        hitvec_d        = hitvec_q;
        victim_d        = victim_q;
        target_d        = target_q;
        evict_d         = evict_q;
        count_d         = count_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_hit_d       = rsp_hit_q;
        rsp_addr_d      = rsp_addr_q;
        rsp_evict_d     = rsp_evict_q;
        cam_data_d      = cam_data_q;
        cam_write_en_d  = '0;
        cam_search_en_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    op_d        = bus.req_op;
                    cam_data_d  = bus.req_data;
                    rsp_evict_d = 1'b0;
                    rsp_hit_d   = 1'b0;
                    rsp_addr_d  = '0;
                    if (bus.req_op == c_op_search || bus.req_op == c_op_insert) begin
                        state_d         = S_SEARCH;
                        cam_search_en_d = 1'b1;
                    end else begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        if (bus.req_op == c_op_delete) begin
                            rsp_addr_d = bus.req_addr;
                            // Out-of-range rows answer a miss and touch nothing
                            if (w_del_in_range) begin
                                rsp_hit_d             = valid_q[bus.req_addr];
                                valid_d[bus.req_addr] = 1'b0;
                                if (valid_q[bus.req_addr]) begin
                                    count_d = count_q - 1'b1;
                                end
                            end
                        end
                    end
                end
            end
            S_SEARCH: begin
                hitvec_d = cam_match_array & valid_q;
                state_d  = S_EVAL;
            end
            S_EVAL: begin
                if (w_hit_found) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_hit_d   = 1'b1;
                    rsp_addr_d  = w_hit_idx;
                end else if (op_q == c_op_search) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d                      = S_WRITE;
                    target_d                     = w_ins_target;
                    evict_d                      = !w_free_found;
                    cam_write_en_d[w_ins_target] = 1'b1;
                end
            end
            S_WRITE: begin
                valid_d[target_q] = 1'b1;
                if (evict_q) begin
                    victim_d = (victim_q == c_last_row) ? '0 : victim_q + 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                rsp_hit_d   = 1'b0;
                rsp_addr_d  = target_q;
                rsp_evict_d = evict_q;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            op_q            <= '0;
            valid_q         <= '0;
            hitvec_q        <= '0;
            victim_q        <= '0;
            target_q        <= '0;
            evict_q         <= 1'b0;
            count_q         <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_hit_q       <= 1'b0;
            rsp_addr_q      <= '0;
            rsp_evict_q     <= 1'b0;
            cam_write_en_q  <= '0;
            cam_search_en_q <= 1'b0;
            cam_data_q      <= '0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            valid_q         <= valid_d;
            hitvec_q        <= hitvec_d;
            victim_q        <= victim_d;
            target_q        <= target_d;
            evict_q         <= evict_d;
            count_q         <= count_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_hit_q       <= rsp_hit_d;
            rsp_addr_q      <= rsp_addr_d;
            rsp_evict_q     <= rsp_evict_d;
            cam_write_en_q  <= cam_write_en_d;
            cam_search_en_q <= cam_search_en_d;
            cam_data_q      <= cam_data_d;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_hit   = rsp_hit_q;
    assign bus.rsp_addr  = rsp_addr_q;
    assign bus.rsp_evict = rsp_evict_q;
    assign entry_count   = count_q;
    assign cam_data      = cam_data_q;
    assign cam_write_en  = cam_write_en_q;
    assign cam_search_en = cam_search_en_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cam_ctrl
//  Description : Directed self-checking bench for cam_ctrl with a CAM array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_ctrl;

    localparam int WORD_SIZE   = 16;
    localparam int ROW_NUM     = 68;
    localparam int ENTRY_WIDTH = 7;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [ENTRY_WIDTH:0]   entry_count;
    logic [WORD_SIZE-1:0]   cam_data;
    logic [ROW_NUM-1:0]     cam_write_en;
    logic                   cam_search_en;
    logic [ROW_NUM-1:0]     cam_match_array;

    logic [WORD_SIZE-1:0]   mem [ROW_NUM];

    int n_chk   = 0;
    int n_fail  = 0;
    int wr_cyc  = 0;
    int se_cyc  = 0;
    int multi_wr = 0;

    cam_ctrl_if #(.WORD_SIZE(WORD_SIZE), .ENTRY_WIDTH(ENTRY_WIDTH)) ifc ();

    cam_ctrl #(
        .WORD_SIZE   (WORD_SIZE),
        .ROW_NUM     (ROW_NUM),
        .ENTRY_WIDTH (ENTRY_WIDTH)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (ifc),
        .entry_count     (entry_count),
        .cam_data        (cam_data),
        .cam_write_en    (cam_write_en),
        .cam_search_en   (cam_search_en),
        .cam_match_array (cam_match_array)
    );

    always #5 clk = ~clk;

    // CAM array: per-row latches and raw comparators, not cleared by reset
    initial begin
        for (int i = 0; i < ROW_NUM; i++) mem[i] <= '0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < ROW_NUM; i++) begin
            if (cam_write_en[i]) mem[i] <= cam_data;
        end
        if (cam_write_en != '0) wr_cyc++;
        if (cam_search_en) se_cyc++;
        if ($countones(cam_write_en) > 1) multi_wr++;
    end

    always_comb begin
        cam_match_array = '0;
        for (int i = 0; i < ROW_NUM; i++) cam_match_array[i] = (mem[i] == cam_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] d, input logic [6:0] a);
        int k;
        k = 0;
        @(negedge clk);
        while (!ifc.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!ifc.req_ready) check("req_ready_timeout", 32'(ifc.req_ready), 32'd1);
        ifc.req_valid = 1'b1;
        ifc.req_op    = op;
        ifc.req_data  = d;
        ifc.req_addr  = a;
        @(posedge clk);
        #1 ifc.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!ifc.rsp_valid && lat < 12) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!ifc.rsp_valid) check("rsp_timeout", 32'(ifc.rsp_valid), 32'd1);
    endtask

    task automatic release_rsp();
        ifc.rsp_ready = 1'b1;
        @(posedge clk);
        #1 ifc.rsp_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [15:0] d,
                       input logic [6:0] a, input int e_lat, input logic e_hit,
                       input logic [6:0] e_addr, input logic e_ev, input int e_cnt);
        int lat;
        send(op, d, a);
        wait_rsp(lat);
        check({tag, "_lat"},   32'(lat),             32'(e_lat));
        check({tag, "_hit"},   32'(ifc.rsp_hit),     32'(e_hit));
        check({tag, "_addr"},  32'(ifc.rsp_addr),    32'(e_addr));
        check({tag, "_evict"}, 32'(ifc.rsp_evict),   32'(e_ev));
        check({tag, "_count"}, 32'(entry_count),     32'(e_cnt));
        release_rsp();
    endtask

    initial begin
        int w0, lat, bad, k;
        logic [ROW_NUM-1:0] exp_we;

        ifc.req_valid = 1'b0;
        ifc.req_op    = 2'b00;
        ifc.req_data  = '0;
        ifc.req_addr  = '0;
        ifc.rsp_ready = 1'b0;

        #23;
        check("rst_req_ready", 32'(ifc.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        check("rst_count",     32'(entry_count),   32'd0);
        check("rst_cam_data",  32'(cam_data),      32'd0);
        check("rst_search_en", 32'(cam_search_en), 32'd0);
        check("rst_write_en",  32'(cam_write_en != '0), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        w0 = se_cyc;
        run("srch_empty", 2'b00, 16'h1234, 7'd0, 3, 1'b0, 7'd0, 1'b0, 0);
        check("srch_en_cycles", 32'(se_cyc - w0), 32'd1);

        w0 = wr_cyc;
        run("ins_first", 2'b01, 16'hABCD, 7'd0, 4, 1'b0, 7'd0, 1'b0, 1);
        check("ins_first_wr", 32'(wr_cyc - w0), 32'd1);
        w0 = wr_cyc;
        run("ins_dup", 2'b01, 16'hABCD, 7'd0, 3, 1'b1, 7'd0, 1'b0, 1);
        check("ins_dup_wr", 32'(wr_cyc - w0), 32'd0);

        for (int i = 1; i < ROW_NUM; i++) begin
            send(2'b01, 16'h1000 + 16'(i), 7'd0);
            wait_rsp(lat);
            check("fill_addr", 32'(ifc.rsp_addr), 32'(i));
            release_rsp();
        end
        check("fill_count", 32'(entry_count), 32'd68);

        run("evict0", 2'b01, 16'h5555, 7'd0, 4, 1'b0, 7'd0, 1'b1, 68);
        run("evict1", 2'b01, 16'h6666, 7'd0, 4, 1'b0, 7'd1, 1'b1, 68);
        run("srch_gone",  2'b00, 16'hABCD, 7'd0, 3, 1'b0, 7'd0, 1'b0, 68);
        run("srch_row5",  2'b00, 16'h1005, 7'd0, 3, 1'b1, 7'd5, 1'b0, 68);

        run("del5",       2'b10, 16'h0000, 7'd5,   1, 1'b1, 7'd5,   1'b0, 67);
        run("del5_again", 2'b10, 16'h0000, 7'd5,   1, 1'b0, 7'd5,   1'b0, 67);
        run("del_oor",    2'b10, 16'h0000, 7'd100, 1, 1'b0, 7'd100, 1'b0, 67);
        run("reserved",   2'b11, 16'h4321, 7'd33,  1, 1'b0, 7'd0,   1'b0, 67);

        run("ins_hole",   2'b01, 16'h7777, 7'd0, 4, 1'b0, 7'd5, 1'b0, 68);
        run("srch_old5",  2'b00, 16'h1005, 7'd0, 3, 1'b0, 7'd0, 1'b0, 68);
        run("del10",      2'b10, 16'h0000, 7'd10, 1, 1'b1, 7'd10, 1'b0, 67);
        run("srch_inval", 2'b00, 16'h100A, 7'd0, 3, 1'b0, 7'd0, 1'b0, 67);

        // Stalled response must hold every output steady
        send(2'b00, 16'h7777, 7'd0);
        wait_rsp(lat);
        bad = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!ifc.rsp_valid || !ifc.rsp_hit || ifc.rsp_addr != 7'd5 ||
                ifc.rsp_evict || cam_data != 16'h7777 || !(ifc.req_ready == 1'b0))
                bad++;
        end
        check("stall_hold", 32'(bad), 32'd0);
        check("stall_addr", 32'(ifc.rsp_addr), 32'd5);
        release_rsp();

        // Reset while the insert sits in its write cycle
        send(2'b01, 16'h8888, 7'd0);
        k = 0;
        while (cam_write_en == '0 && k < 10) begin
            @(posedge clk);
            #1 k++;
        end
        exp_we = '0;
        exp_we[10] = 1'b1;
        check("write_row10", 32'(cam_write_en == exp_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstw_write_en",  32'(cam_write_en != '0), 32'd0);
        check("rstw_count",     32'(entry_count),        32'd0);
        check("rstw_rsp_valid", 32'(ifc.rsp_valid),      32'd0);
        check("rstw_req_ready", 32'(ifc.req_ready),      32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run("post_rst_srch", 2'b00, 16'h7777, 7'd0, 3, 1'b0, 7'd0, 1'b0, 0);
        run("post_rst_ins",  2'b01, 16'h9999, 7'd0, 4, 1'b0, 7'd0, 1'b0, 1);
        check("onehot_write", 32'(multi_wr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
